// File: rtl/spram_arbiter.sv
// Two-port arbiter/sequencer for one 16K x 16 SPRAM; reads return on the owning port 3 cycles after accept.
// Combinational grant, one request per cycle, no stalls; responses cannot be backpressured.
`timescale 1ns/1ps
module spram_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [13:0] req0_address,
  input  logic [15:0] req0_wdata,
  input  logic [3:0]  req0_mask,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [13:0] req1_address,
  input  logic [15:0] req1_wdata,
  input  logic [3:0]  req1_mask,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,
  output logic        ram_chipselect,
  output logic        ram_wren,
  output logic [13:0] ram_address,
  output logic [15:0] ram_datain,
  output logic [3:0]  ram_maskwren,
  input  logic [15:0] ram_dataout
);

  logic        last_grant_q, last_grant_d;
  logic        gnt0, gnt1, accept;
  logic        sel_write;
  logic [13:0] sel_address;
  logic [15:0] sel_wdata;
  logic [3:0]  sel_mask;

  logic        cs_q, cs_d;
  logic        wren_q, wren_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [3:0]  mask_q, mask_d;

  // Tag pipeline: {is_read, port}; S1 aligns with the SPRAM pins, S2 with ram_dataout.
  logic        s1_rd_q, s1_rd_d, s1_port_q, s1_port_d;
  logic        s2_rd_q, s2_port_q;

  logic        rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
  logic [15:0] rsp0_dat_q, rsp0_dat_d, rsp1_dat_q, rsp1_dat_d;

  // last_grant_q == 1 means port 1 won last, so port 0 takes the next contention.
  assign gnt0   = req0_valid & (~req1_valid | (ROUND_ROBIN == 1'b0) | last_grant_q);
  assign gnt1   = req1_valid & ~gnt0;
  assign accept = gnt0 | gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sel_write   = gnt1 ? req1_write   : req0_write;
  assign sel_address = gnt1 ? req1_address : req0_address;
  assign sel_wdata   = gnt1 ? req1_wdata   : req0_wdata;
  assign sel_mask    = gnt1 ? req1_mask    : req0_mask;

  always_comb begin
    last_grant_d = last_grant_q;
    cs_d         = 1'b0;
    wren_d       = 1'b0;
    mask_d       = 4'b0000;
    addr_d       = addr_q;
    din_d        = din_q;
    s1_rd_d      = 1'b0;
    s1_port_d    = s1_port_q;
    if (accept) begin
      last_grant_d = gnt1;
      cs_d         = 1'b1;
      wren_d       = sel_write;
      mask_d       = sel_write ? sel_mask : 4'b0000;
      addr_d       = sel_address;
      din_d        = sel_wdata;
      s1_rd_d      = ~sel_write;
      s1_port_d    = gnt1;
    end
  end

  always_comb begin
    rsp0_vld_d = s2_rd_q & ~s2_port_q;
    rsp1_vld_d = s2_rd_q &  s2_port_q;
    rsp0_dat_d = rsp0_vld_d ? ram_dataout : rsp0_dat_q;
    rsp1_dat_d = rsp1_vld_d ? ram_dataout : rsp1_dat_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      cs_q         <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= 14'd0;
      din_q        <= 16'd0;
      mask_q       <= 4'd0;
      s1_rd_q      <= 1'b0;
      s1_port_q    <= 1'b0;
      s2_rd_q      <= 1'b0;
      s2_port_q    <= 1'b0;
      rsp0_vld_q   <= 1'b0;
      rsp1_vld_q   <= 1'b0;
      rsp0_dat_q   <= 16'd0;
      rsp1_dat_q   <= 16'd0;
    end else begin
      last_grant_q <= last_grant_d;
      cs_q         <= cs_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      mask_q       <= mask_d;
      s1_rd_q      <= s1_rd_d;
      s1_port_q    <= s1_port_d;
      s2_rd_q      <= s1_rd_q;
      s2_port_q    <= s1_port_q;
      rsp0_vld_q   <= rsp0_vld_d;
      rsp1_vld_q   <= rsp1_vld_d;
      rsp0_dat_q   <= rsp0_dat_d;
      rsp1_dat_q   <= rsp1_dat_d;
    end
  end

  assign ram_chipselect = cs_q;
  assign ram_wren       = wren_q;
  assign ram_address    = addr_q;
  assign ram_datain     = din_q;
  assign ram_maskwren   = mask_q;
  assign rsp0_valid     = rsp0_vld_q;
  assign rsp1_valid     = rsp1_vld_q;
  assign rsp0_rdata     = rsp0_dat_q;
  assign rsp1_rdata     = rsp1_dat_q;

endmodule
